// File: rtl/dmem_bus_bridge.sv
// Data-memory bridge: turns the core's single-cycle load/store into a valid/ready
// bus transaction, stalls the core until completion and flags bus timeouts.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wmask,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        core_done,
  output logic        core_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES != 32'd0) ?
                                          CNT_W'(TIMEOUT_CYCLES - 32'd1) : {CNT_W{1'b0}};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [3:0]       wstrb_r;
  logic [31:0]      rdata_r;
  logic             err_r;
  logic             timeout_s;
  logic             stall_s;
  logic             unused_s;

  // Byte offset is irrelevant on a word-wide bus.
  assign unused_s  = ^core_addr[1:0];
  assign timeout_s = (TIMEOUT_CYCLES != 32'd0) && (cnt_r == CNT_LAST);

  // Next-state selection; ready takes priority over an expiring timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (core_req) state_nxt_s = ST_BUS;
        else          state_nxt_s = ST_IDLE;
      end
      ST_BUS: begin
        if (mem_ready)      state_nxt_s = ST_DONE;
        else if (timeout_s) state_nxt_s = ST_DONE;
        else                state_nxt_s = ST_BUS;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Stall decode: in IDLE the request itself must hold the core for one cycle.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE: stall_s = core_req;
      ST_BUS:  stall_s = 1'b1;
      ST_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Request latches, wait counter, read-data capture and error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      wstrb_r <= 4'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (core_req) begin
            addr_r  <= {core_addr[31:2], 2'b00};
            wdata_r <= core_wdata;
            wstrb_r <= core_wmask;
            err_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        ST_BUS: begin
          if (mem_ready) begin
            if (wstrb_r == 4'd0) rdata_r <= mem_rdata;
          end else if (timeout_s) begin
            err_r <= 1'b1;
            if (wstrb_r == 4'd0) rdata_r <= 32'd0;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          err_r <= err_r;
        end
        default: begin
          err_r <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are decodes of registered state so mem_ready never reaches the core directly.
  assign mem_valid  = (state_r == ST_BUS);
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign mem_wstrb  = wstrb_r;
  assign core_rdata = rdata_r;
  assign core_done  = (state_r == ST_DONE);
  assign core_err   = (state_r == ST_DONE) && err_r;
  assign core_stall = stall_s;

endmodule
